// File: rtl/song_pkg.sv
// Shared widths, field positions and state encoding for the song sequencer.
package song_pkg;

    localparam int SONG_BITS = 2;
    localparam int IDX_BITS  = 5;
    localparam int NOTE_BITS = 6;
    localparam int DUR_BITS  = 6;

    localparam int ADDR_BITS = SONG_BITS + IDX_BITS;
    localparam int DATA_BITS = NOTE_BITS + DUR_BITS;

    // rom_data layout: {note, duration}
    localparam int NOTE_MSB = DATA_BITS - 1;
    localparam int NOTE_LSB = DUR_BITS;
    localparam int DUR_MSB  = DUR_BITS - 1;
    localparam int DUR_LSB  = 0;

    // A zero duration marks the end of a song.
    localparam logic [DUR_BITS-1:0] END_DURATION = '0;
    localparam logic [IDX_BITS-1:0] LAST_IDX     = '1;

    localparam int STATE_BITS = 3;
    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_ISSUE   = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_ADVANCE = 3'd5;
    localparam logic [2:0] ST_END     = 3'd6;
    localparam logic [2:0] ST_HOLD    = 3'd7;

    function automatic logic [NOTE_BITS-1:0] note_field(input logic [DATA_BITS-1:0] word);
        return word[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [DUR_BITS-1:0] dur_field(input logic [DATA_BITS-1:0] word);
        return word[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/song_reader_if.sv
// Bus between the song sequencer and its neighbours (MCU controls, song ROM,
// note player), plus a debug view of the sequencer state.
//
// Handshake: there is no valid/ready back-pressure on this bus. new_note is a
// one-cycle pulse that qualifies note/duration (which then stay stable until
// the next capture); note_done is a one-cycle pulse from the note player and
// is only observed while the sequencer is waiting on a note. rom_data answers
// rom_addr exactly one cycle later.
interface song_reader_if;
    import song_pkg::*;

    logic                   play;
    logic [SONG_BITS-1:0]   song;
    logic                   note_done;
    logic [ADDR_BITS-1:0]   rom_addr;
    logic [DATA_BITS-1:0]   rom_data;
    logic                   new_note;
    logic [NOTE_BITS-1:0]   note;
    logic [DUR_BITS-1:0]    duration;
    logic                   song_done;
    logic [STATE_BITS-1:0]  state_dbg;

    // Environment side: MCU controls, ROM data and note_player feedback.
    modport master (
        output play, song, note_done, rom_data,
        input  rom_addr, new_note, note, duration, song_done, state_dbg
    );

    // Sequencer side.
    modport slave (
        input  play, song, note_done, rom_data,
        output rom_addr, new_note, note, duration, song_done, state_dbg
    );

endinterface

// File: rtl/song_reader.sv
// Walks the selected song in ROM and hands notes one at a time to the note
// player, waiting for each to finish before fetching the next.
module song_reader
    import song_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    song_reader_if.slave bus
);

    logic [STATE_BITS-1:0] state_q, state_d;
    logic [IDX_BITS-1:0]   note_idx_q, note_idx_d;
    logic [SONG_BITS-1:0]  song_reg_q, song_reg_d;
    logic [NOTE_BITS-1:0]  note_q, note_d;
    logic [DUR_BITS-1:0]   duration_q, duration_d;

    // Next-state and datapath update; a song change overrides every transition.
    always_comb begin
        state_d    = state_q;
        note_idx_d = note_idx_q;
        song_reg_d = song_reg_q;
        note_d     = note_q;
        duration_d = duration_q;

        case (state_q)
            ST_RESET: begin
                note_idx_d = '0;
                song_reg_d = bus.song;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                // Stall here while paused so the ROM read is not consumed.
                if (bus.play) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                note_d     = note_field(bus.rom_data);
                duration_d = dur_field(bus.rom_data);
                if (dur_field(bus.rom_data) == END_DURATION) state_d = ST_END;
                else                                         state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Pausing mid-note is the note player's job, not ours.
                if (bus.note_done) state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                if (note_idx_q == LAST_IDX) begin
                    state_d = ST_END;
                end else begin
                    note_idx_d = note_idx_q + 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_END: begin
                note_idx_d = '0;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_HOLD;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        if (state_q != ST_RESET && bus.song != song_reg_q) begin
            state_d = ST_RESET;
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            note_idx_q <= '0;
            song_reg_q <= '0;
            note_q     <= '0;
            duration_q <= '0;
        end else begin
            state_q    <= state_d;
            note_idx_q <= note_idx_d;
            song_reg_q <= song_reg_d;
            note_q     <= note_d;
            duration_q <= duration_d;
        end
    end

    assign bus.rom_addr  = {song_reg_q, note_idx_q};
    assign bus.new_note  = (state_q == ST_ISSUE);
    assign bus.song_done = (state_q == ST_END);
    assign bus.note      = note_q;
    assign bus.duration  = duration_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: cycle tables for the fixed sequences, hand-written
// sequences for full-song and song-switch cases, and a note scoreboard.
module tb_song_reader;
    import song_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    song_reader_if bus ();

    song_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    // Synchronous song ROM model.
    logic [DATA_BITS-1:0] rom_mem [0:127];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    // Scoreboard: bit 12 set = song_done event, else {note, duration}.
    logic [12:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic        play;
        logic        nd;
        logic [1:0]  song;
        int          reps;
        logic [2:0]  st;
        logic        nn;
        logic        sd;
        logic [6:0]  addr;
        logic        chk;
        logic [11:0] data;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [11:0] word(input int n, input int d);
        logic [5:0] nb;
        logic [5:0] db;
        nb = n[5:0];
        db = d[5:0];
        return {nb, db};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every new_note / song_done is matched against the scoreboard.
    always @(negedge clk) begin
        logic [12:0] act;
        logic [12:0] e;
        if (!reset && (bus.new_note || bus.song_done)) begin
            act = bus.song_done ? 13'h1000 : {1'b0, bus.note, bus.duration};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %0h expected no event at %0t", act, $time);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL sb_event: got %0h expected %0h at %0t", act, e, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int rst, input int play, input int nd, input int song, input int reps,
                       input logic [2:0] st, input int nn, input int sd, input logic [6:0] addr,
                       input int chk, input logic [11:0] data);
        vec_t v;
        v.rst  = rst[0];
        v.play = play[0];
        v.nd   = nd[0];
        v.song = song[1:0];
        v.reps = reps;
        v.st   = st;
        v.nn   = nn[0];
        v.sd   = sd[0];
        v.addr = addr;
        v.chk  = chk[0];
        v.data = data;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int r = 0; r < tbl.size(); r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                reset         = tbl[r].rst;
                bus.play      = tbl[r].play;
                bus.note_done = tbl[r].nd;
                bus.song      = tbl[r].song;
                step();
                check($sformatf("%s_row%0d", tag, r),
                      {20'd0, bus.state_dbg, bus.new_note, bus.song_done, bus.rom_addr},
                      {20'd0, tbl[r].st, tbl[r].nn, tbl[r].sd, tbl[r].addr});
                if (tbl[r].chk)
                    check($sformatf("%s_data%0d", tag, r), {20'd0, bus.note, bus.duration},
                          {20'd0, tbl[r].data});
            end
        end
        bus.note_done = 1'b0;
        tbl.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_nn(input string name, input int budget);
        int k;
        k = 0;
        while (!bus.new_note && k < budget) begin
            step();
            k++;
        end
        check(name, {31'd0, bus.new_note}, 32'd1);
    endtask

    task automatic pulse_nd();
        bus.note_done = 1'b1;
        step();
        bus.note_done = 1'b0;
    endtask

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.play      = 1'b0;
        bus.song      = 2'd0;
        bus.note_done = 1'b0;
        for (int i = 0; i < 128; i++) rom_mem[i] = word(1, 1);
        rom_mem[0] = word(5, 10);
        rom_mem[1] = word(7, 3);
        rom_mem[2] = word(9, 0);
        for (int i = 0; i < 32; i++) rom_mem[32 + i] = word(i + 1, (i % 7) + 1);
        rom_mem[96] = word(20, 0);
        rom_mem[64] = word(33, 17);

        // Three-word song with end marker, play held high.
        exp_q.push_back({1'b0, word(5, 10)});
        exp_q.push_back({1'b0, word(7, 3)});
        exp_q.push_back(13'h1000);
        add(1, 1, 0, 0, 2,  ST_RESET,   0, 0, 7'd0, 1, 12'd0);
        add(0, 1, 0, 0, 1,  ST_FETCH,   0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 0, 0, 1,  ST_CAPTURE, 0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 0, 0, 1,  ST_ISSUE,   1, 0, 7'd0, 1, word(5, 10));
        add(0, 1, 0, 0, 19, ST_WAIT,    0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 1, 0, 1,  ST_ADVANCE, 0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 0, 0, 1,  ST_FETCH,   0, 0, 7'd1, 0, 12'd0);
        add(0, 1, 0, 0, 1,  ST_CAPTURE, 0, 0, 7'd1, 0, 12'd0);
        add(0, 1, 0, 0, 1,  ST_ISSUE,   1, 0, 7'd1, 1, word(7, 3));
        add(0, 1, 0, 0, 5,  ST_WAIT,    0, 0, 7'd1, 0, 12'd0);
        add(0, 1, 1, 0, 1,  ST_ADVANCE, 0, 0, 7'd1, 0, 12'd0);
        add(0, 1, 0, 0, 1,  ST_FETCH,   0, 0, 7'd2, 0, 12'd0);
        add(0, 1, 0, 0, 1,  ST_CAPTURE, 0, 0, 7'd2, 0, 12'd0);
        add(0, 1, 0, 0, 1,  ST_END,     0, 1, 7'd2, 0, 12'd0);
        add(0, 1, 0, 0, 8,  ST_HOLD,    0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 1, 0, 1,  ST_HOLD,    0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 0, 0, 3,  ST_HOLD,    0, 0, 7'd0, 0, 12'd0);
        run_table("basic");

        // Pause in FETCH, stray note_done, then reset during CAPTURE.
        exp_q.push_back({1'b0, word(5, 10)});
        add(1, 0, 0, 0, 2, ST_RESET,   0, 0, 7'd0, 1, 12'd0);
        add(0, 0, 0, 0, 5, ST_FETCH,   0, 0, 7'd0, 0, 12'd0);
        add(0, 0, 1, 0, 1, ST_FETCH,   0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 0, 0, 1, ST_CAPTURE, 0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 0, 0, 1, ST_ISSUE,   1, 0, 7'd0, 1, word(5, 10));
        add(0, 1, 1, 0, 1, ST_WAIT,    0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 0, 0, 3, ST_WAIT,    0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 1, 0, 1, ST_ADVANCE, 0, 0, 7'd0, 0, 12'd0);
        add(0, 1, 0, 0, 1, ST_FETCH,   0, 0, 7'd1, 0, 12'd0);
        add(0, 1, 0, 0, 1, ST_CAPTURE, 0, 0, 7'd1, 0, 12'd0);
        add(1, 1, 0, 0, 1, ST_RESET,   0, 0, 7'd0, 1, 12'd0);
        run_table("pause");

        // End marker at word 0 of song 3.
        exp_q.push_back(13'h1000);
        add(1, 1, 0, 3, 2, ST_RESET,   0, 0, 7'd0,        1, 12'd0);
        add(0, 1, 0, 3, 1, ST_FETCH,   0, 0, 7'b11_00000, 0, 12'd0);
        add(0, 1, 0, 3, 1, ST_CAPTURE, 0, 0, 7'b11_00000, 0, 12'd0);
        add(0, 1, 0, 3, 1, ST_END,     0, 1, 7'b11_00000, 1, word(20, 0));
        add(0, 1, 0, 3, 5, ST_HOLD,    0, 0, 7'b11_00000, 0, 12'd0);
        run_table("empty");

        // Full 32-note song 1 with random note lengths, then last-address wrap.
        bus.song = 2'd1;
        bus.play = 1'b1;
        for (int i = 0; i < 32; i++) exp_q.push_back({1'b0, word(i + 1, (i % 7) + 1)});
        exp_q.push_back(13'h1000);
        do_reset();
        for (int i = 0; i < 32; i++) begin
            wait_nn($sformatf("full_nn%0d", i), 10);
            repeat ($urandom_range(1, 5)) step();
            pulse_nd();
        end
        begin
            int k;
            k = 0;
            while (!bus.song_done && k < 10) begin
                step();
                k++;
            end
            check("full_done", {31'd0, bus.song_done}, 32'd1);
        end
        step();
        check("full_wrap", {22'd0, bus.state_dbg, bus.rom_addr}, {22'd0, ST_HOLD, 7'b01_00000});
        repeat (20) step();

        // Song switch while waiting on note 4 of song 0; concurrent note_done dropped.
        rom_mem[2] = word(11, 4);
        rom_mem[3] = word(12, 5);
        rom_mem[4] = word(13, 6);
        rom_mem[5] = word(0, 0);
        bus.song = 2'd0;
        exp_q.push_back({1'b0, word(5, 10)});
        exp_q.push_back({1'b0, word(7, 3)});
        exp_q.push_back({1'b0, word(11, 4)});
        exp_q.push_back({1'b0, word(12, 5)});
        exp_q.push_back({1'b0, word(13, 6)});
        exp_q.push_back({1'b0, word(33, 17)});
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wait_nn($sformatf("switch_nn%0d", i), 10);
            step();
            if (i < 4) pulse_nd();
        end
        check("switch_wait", {22'd0, bus.state_dbg, bus.rom_addr}, {22'd0, ST_WAIT, 7'b00_00100});
        bus.song      = 2'd2;
        bus.note_done = 1'b1;
        step();
        bus.note_done = 1'b0;
        check("switch_reset", {29'd0, bus.state_dbg}, {29'd0, ST_RESET});
        step();
        check("switch_fetch", {22'd0, bus.state_dbg, bus.rom_addr}, {22'd0, ST_FETCH, 7'b10_00000});
        step();
        step();
        check("switch_issue", {19'd0, bus.new_note, bus.note, bus.duration},
              {19'd0, 1'b1, word(33, 17)});
        repeat (3) step();

        check("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
